// File: rtl/bfsm_if.sv
// bfsm_if: requester and detector signals of bfsm_arbiter.
interface bfsm_if #(
    parameter int W  = 8,
    parameter int CW = 4
);
    logic [1:0]    req;
    logic [W-1:0]  data0;
    logic [W-1:0]  data1;
    logic [1:0]    gnt;
    logic [1:0]    ack;
    logic [CW-1:0] ycnt;
    logic          busy;
    logic          fsm_rst;
    logic          fsm_x;
    logic          fsm_y;
    modport master (output req, data0, data1, fsm_y, input gnt, ack, ycnt, busy, fsm_rst, fsm_x);
    modport slave  (input req, data0, data1, fsm_y, output gnt, ack, ycnt, busy, fsm_rst, fsm_x);
endinterface

// File: rtl/bfsm_arbiter.sv
// bfsm_arbiter: round-robin sharing of one serial Mealy detector between two requesters.
module bfsm_arbiter #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input logic   CLK,
    input logic   RST,
    bfsm_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;
    state_t        state, next;
    logic [1:0]    gnt;
    logic [W-1:0]  sr;
    logic [CW-1:0] bc, ycnt;
    logic          last, g1;
    // requester 1 wins when alone, or on a tie when requester 0 was served last
    assign g1 = bus.req[1] & (~bus.req[0] | ~last);
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = |bus.req ? CLR : IDLE;
            CLR:     next = SHIFT;
            SHIFT:   next = bc == CW'(W - 1) ? DONE : SHIFT;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            gnt   <= 2'b00;
            sr    <= '0;
            bc    <= '0;
            ycnt  <= '0;
            last  <= 1'b1;
        end else begin
            state <= next;
            case (state)
                IDLE: if (|bus.req) begin
                    gnt  <= {g1, ~g1};
                    sr   <= g1 ? bus.data1 : bus.data0;
                    last <= g1;
                end
                CLR: begin
                    ycnt <= '0;
                    bc   <= '0;
                end
                SHIFT: begin
                    ycnt <= ycnt + CW'(bus.fsm_y);
                    sr   <= sr >> 1;
                    bc   <= bc + 1'b1;
                end
                default: gnt <= 2'b00;
            endcase
        end
    end
    assign bus.gnt     = gnt;
    assign bus.ack     = state == DONE ? gnt : 2'b00;
    assign bus.ycnt    = ycnt;
    assign bus.busy    = state != IDLE;
    assign bus.fsm_rst = RST | (state == CLR);
    assign bus.fsm_x   = (state == SHIFT) & sr[0];
endmodule
